// File: rtl/vga_reg_writer_pkg.sv
// rtl/vga_reg_writer_pkg.sv - shared types and constants for the sprite register writer
package vga_reg_writer_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_DINO_X     = 9'd0;
    localparam logic [ADDR_W_DEF-1:0] REG_DINO_Y     = 9'd1;
    localparam logic [ADDR_W_DEF-1:0] REG_DINO_FRAME = 9'd2;
    localparam logic [ADDR_W_DEF-1:0] REG_CACTUS0_X  = 9'd3;
    localparam logic [ADDR_W_DEF-1:0] REG_CACTUS0_Y  = 9'd4;
    localparam logic [ADDR_W_DEF-1:0] REG_CACTUS1_X  = 9'd5;
    localparam logic [ADDR_W_DEF-1:0] REG_CACTUS1_Y  = 9'd6;
    localparam logic [ADDR_W_DEF-1:0] REG_BIRD_X     = 9'd7;
    localparam logic [ADDR_W_DEF-1:0] REG_BIRD_Y     = 9'd8;
    localparam logic [ADDR_W_DEF-1:0] REG_GROUND_X   = 9'd9;
    localparam logic [ADDR_W_DEF-1:0] REG_SCORE      = 9'd10;
    localparam logic [ADDR_W_DEF-1:0] REG_SCORE_X    = 9'd11;
    localparam logic [ADDR_W_DEF-1:0] REG_SCORE_Y    = 9'd12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } cmd_t;

endpackage

// File: rtl/vga_reg_writer_if.sv
// rtl/vga_reg_writer_if.sv - command stream in, Avalon-MM write bus out
// Modport names follow the Avalon role: master is the writer, slave is its environment.
interface vga_reg_writer_if
    import vga_reg_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              avm_chipselect;
    logic              avm_write;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, avm_waitrequest,
        output cmd_ready, avm_chipselect, avm_write, avm_address, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, avm_waitrequest,
        input  cmd_ready, avm_chipselect, avm_write, avm_address, avm_writedata
    );

endinterface

// File: rtl/reg_cmd_fifo.sv
// rtl/reg_cmd_fifo.sv - synchronous command FIFO with registered count and head/next peek
module reg_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [WIDTH-1:0]       next_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_next = rd_ptr_q + PTR_W'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next];
    assign count_o = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_next;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vga_reg_writer.sv
// rtl/vga_reg_writer.sv - queues sprite register writes and issues them over Avalon-MM
// VGA_REG_WRITER_VBLANK_SYNC_EN: when defined, writes only start while vblank is high.
module vga_reg_writer
    import vga_reg_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    vga_reg_writer_if.master            bus,
    input  logic                        vblank,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 write_count,
    output logic                        frame_tick
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CMD_W = ADDR_W + DATA_W;

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  head, next_e, load_e, in_e;
    logic [LVL_W-1:0]  count;
    logic              full, empty, push, pop, load, gate, more;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       write_count_q;
    logic              vblank_q, frame_tick_q;

`ifdef VGA_REG_WRITER_VBLANK_SYNC_EN
    assign gate = vblank;
`else
    assign gate = 1'b1;
`endif

    assign in_e          = {bus.cmd_addr, bus.cmd_data};
    assign push          = bus.cmd_valid && !full;
    assign bus.cmd_ready = !full;
    // An entry pushed on the popping edge still counts as the next write.
    assign more          = (count > LVL_W'(1)) || push;

    reg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (in_e),
        .pop_i       (pop),
        .head_o      (head),
        .next_o      (next_e),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!empty && gate) state_d = ST_WRITE;
            ST_WRITE: if (!bus.avm_waitrequest && !(more && gate)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop                = 1'b0;
        load               = 1'b0;
        load_e             = head;
        bus.avm_chipselect = 1'b0;
        bus.avm_write      = 1'b0;
        case (state_q)
            ST_IDLE: load = !empty && gate;
            ST_WRITE: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write      = 1'b1;
                if (!bus.avm_waitrequest) begin
                    pop    = 1'b1;
                    load   = more && gate;
                    load_e = (count > LVL_W'(1)) ? next_e : in_e;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            data_q        <= '0;
            write_count_q <= '0;
            vblank_q      <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            if (load) begin
                addr_q <= load_e[CMD_W-1:DATA_W];
                data_q <= load_e[DATA_W-1:0];
            end
            if (pop) write_count_q <= write_count_q + 16'd1;
            vblank_q     <= vblank;
            frame_tick_q <= vblank && !vblank_q;
        end
    end

    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = data_q;
    assign fifo_level        = count;
    assign write_count       = write_count_q;
    assign frame_tick        = frame_tick_q;

endmodule

// File: tb/tb_vga_reg_writer.sv
// tb/tb_vga_reg_writer.sv - self-checking bench for vga_reg_writer with a queue scoreboard
module tb_vga_reg_writer;
    import vga_reg_writer_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic [4:0]  fifo_level;
    logic [15:0] write_count;
    logic        frame_tick;

    vga_reg_writer_if #(.ADDR_W(9), .DATA_W(32)) bus();

    vga_reg_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(9), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .vblank      (vblank),
        .fifo_level  (fifo_level),
        .write_count (write_count),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    cmd_t        mq[$];
    logic [15:0] m_count = 16'd0;
    logic        s1 = 1'b0, s2 = 1'b0;
    logic        prev_write = 1'b0, prev_accept = 1'b0, prev_stall = 1'b0;
    logic [8:0]  prev_addr = 9'd0;
    logic [31:0] prev_data = 32'd0;

    // Reference model: commands queue in order; an entry leaves only when a write is accepted.
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_count = 16'd0;
            s1 = 1'b0; s2 = 1'b0;
            prev_write = 1'b0; prev_accept = 1'b0; prev_stall = 1'b0;
            prev_addr = 9'd0; prev_data = 32'd0;
        end else begin
            checks += 5;
            if (int'(fifo_level) != mq.size()) begin
                errors++; $display("FAIL mon_level: got %0d expected %0d", fifo_level, mq.size());
            end
            if (bus.cmd_ready !== (mq.size() != DEPTH)) begin
                errors++; $display("FAIL mon_ready: got %0b expected %0b", bus.cmd_ready, mq.size() != DEPTH);
            end
            if (write_count !== m_count) begin
                errors++; $display("FAIL mon_count: got %0d expected %0d", write_count, m_count);
            end
            if (frame_tick !== (s1 && !s2)) begin
                errors++; $display("FAIL mon_tick: got %0b expected %0b", frame_tick, s1 && !s2);
            end
            if (bus.avm_chipselect !== bus.avm_write) begin
                errors++; $display("FAIL mon_cs: got %0b expected %0b", bus.avm_chipselect, bus.avm_write);
            end
            if (prev_stall || !bus.avm_write) begin
                checks++;
                if (bus.avm_address !== prev_addr || bus.avm_writedata !== prev_data) begin
                    errors++; $display("FAIL mon_hold: got %0d/%h expected %0d/%h",
                                       bus.avm_address, bus.avm_writedata, prev_addr, prev_data);
                end
            end
            if (bus.avm_write) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++; $display("FAIL mon_spurious: got write to %0d expected no write", bus.avm_address);
                end else if (bus.avm_address !== mq[0].addr || bus.avm_writedata !== mq[0].data) begin
                    errors++; $display("FAIL mon_order: got %0d/%h expected %0d/%h",
                                       bus.avm_address, bus.avm_writedata, mq[0].addr, mq[0].data);
                end
`ifdef VGA_REG_WRITER_VBLANK_SYNC_EN
                checks++;
                if ((!prev_write || prev_accept) && !s1) begin
                    errors++; $display("FAIL mon_gate: got write start with vblank %0b expected vblank 1", s1);
                end
`endif
            end
            prev_accept = bus.avm_write && !bus.avm_waitrequest;
            prev_stall  = bus.avm_write && bus.avm_waitrequest;
            prev_write  = bus.avm_write;
            prev_addr   = bus.avm_address;
            prev_data   = bus.avm_writedata;
            if (prev_accept && mq.size() != 0) begin
                void'(mq.pop_front());
                m_count = m_count + 16'd1;
            end
            if (bus.cmd_valid && bus.cmd_ready) mq.push_back({bus.cmd_addr, bus.cmd_data});
            s2 = s1;
            s1 = vblank;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [8:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (n < max_cycles && !(mq.size() == 0 && bus.avm_write == 1'b0)) begin
            tick();
            n++;
        end
        checks++;
        if (mq.size() != 0 || bus.avm_write) begin
            errors++; $display("FAIL drain_timeout: got %0d queued expected 0", mq.size());
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.avm_waitrequest = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            checks += 8;
            if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %0b expected 0", bus.avm_write); end
            if (bus.avm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %0b expected 0", bus.avm_chipselect); end
            if (bus.avm_address !== 9'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.avm_address); end
            if (bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.avm_writedata); end
            if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
            if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", bus.cmd_ready); end
            if (write_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", write_count); end
            if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %0b expected 0", frame_tick); end
            reset = 1'b0;
            tick();
        end
    endtask

    task automatic test_latency();
        logic [15:0] wc0;
        vblank = 1'b1;
        repeat (2) tick();
        wc0 = m_count;
        drive_cmd(9'd10, 32'h3);
        checks++;
        if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b expected 0", bus.avm_write); end
        tick();
        checks += 3;
        if (bus.avm_write !== 1'b1) begin errors++; $display("FAIL lat_write: got %0b expected 1", bus.avm_write); end
        if (bus.avm_address !== 9'd10) begin errors++; $display("FAIL lat_addr: got %0d expected 10", bus.avm_address); end
        if (bus.avm_writedata !== 32'h3) begin errors++; $display("FAIL lat_data: got %h expected 3", bus.avm_writedata); end
        tick();
        checks += 2;
        if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL lat_done: got %0b expected 0", bus.avm_write); end
        if (write_count !== wc0 + 16'd1) begin errors++; $display("FAIL lat_count: got %0d expected %0d", write_count, wc0 + 16'd1); end
    endtask

    task automatic test_waitrequest();
        logic [31:0] d = $urandom();
        logic [15:0] wc0 = m_count;
        vblank = 1'b1;
        bus.avm_waitrequest = 1'b1;
        drive_cmd(9'd3, d);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks += 4;
            if (bus.avm_write !== 1'b1) begin errors++; $display("FAIL wr_stall_write: got %0b expected 1", bus.avm_write); end
            if (bus.avm_address !== 9'd3) begin errors++; $display("FAIL wr_stall_addr: got %0d expected 3", bus.avm_address); end
            if (bus.avm_writedata !== d) begin errors++; $display("FAIL wr_stall_data: got %h expected %h", bus.avm_writedata, d); end
            if (fifo_level !== 5'd1) begin errors++; $display("FAIL wr_stall_level: got %0d expected 1", fifo_level); end
            if (i < 3) tick();
        end
        bus.avm_waitrequest = 1'b0;
        tick();
        checks += 3;
        if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL wr_end_write: got %0b expected 0", bus.avm_write); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL wr_end_level: got %0d expected 0", fifo_level); end
        if (write_count !== wc0 + 16'd1) begin errors++; $display("FAIL wr_end_count: got %0d expected %0d", write_count, wc0 + 16'd1); end
    endtask

    task automatic test_full();
        logic [15:0] wc0 = m_count;
        logic        acc = 1'b0, got = 1'b0;
        int          n = 0;
        vblank = 1'b0;
        bus.avm_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) drive_cmd(9'(i % 13), $urandom());
        checks += 2;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d expected 16", fifo_level); end
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 9'd12;
        bus.cmd_data  = 32'hC0FFEE17;
        repeat (3) tick();
        checks++;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_held: got %0d expected 16", fifo_level); end
        vblank = 1'b1;
        bus.avm_waitrequest = 1'b0;
        while (!got && n < 20) begin
            acc = bus.cmd_ready;
            tick();
            got = acc;
            n++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL full_17th: got not accepted expected accepted"); end
        wait_drain(60);
        checks++;
        if (write_count !== wc0 + 16'd17) begin errors++; $display("FAIL full_count: got %0d expected %0d", write_count, wc0 + 16'd17); end
    endtask

`ifdef VGA_REG_WRITER_VBLANK_SYNC_EN
    task automatic test_gate();
        logic [15:0] wc0 = m_count;
        vblank = 1'b0;
        tick();
        drive_cmd(9'd0, 32'h64);
        drive_cmd(9'd1, 32'h32);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL gate_closed: got %0b expected 0", bus.avm_write); end
            tick();
        end
        vblank = 1'b1;
        tick();
        checks += 2;
        if (bus.avm_write !== 1'b1 || bus.avm_address !== 9'd0) begin errors++; $display("FAIL gate_w0: got %0b/%0d expected 1/0", bus.avm_write, bus.avm_address); end
        if (bus.avm_writedata !== 32'h64) begin errors++; $display("FAIL gate_d0: got %h expected 64", bus.avm_writedata); end
        tick();
        checks += 2;
        if (bus.avm_write !== 1'b1 || bus.avm_address !== 9'd1) begin errors++; $display("FAIL gate_w1: got %0b/%0d expected 1/1", bus.avm_write, bus.avm_address); end
        if (bus.avm_writedata !== 32'h32) begin errors++; $display("FAIL gate_d1: got %h expected 32", bus.avm_writedata); end
        tick();
        checks++;
        if (write_count !== wc0 + 16'd2) begin errors++; $display("FAIL gate_count: got %0d expected %0d", write_count, wc0 + 16'd2); end
    endtask

    task automatic test_stall_vblank();
        logic [31:0] db = $urandom();
        vblank = 1'b1;
        bus.avm_waitrequest = 1'b1;
        drive_cmd(9'd5, $urandom());
        drive_cmd(9'd6, db);
        vblank = 1'b0;
        repeat (2) tick();
        bus.avm_waitrequest = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL stall_next: got %0b expected 0", bus.avm_write); end
            if (fifo_level !== 5'd1) begin errors++; $display("FAIL stall_level: got %0d expected 1", fifo_level); end
            tick();
        end
        vblank = 1'b1;
        tick();
        checks++;
        if (bus.avm_write !== 1'b1 || bus.avm_writedata !== db) begin errors++; $display("FAIL stall_resume: got %0b/%h expected 1/%h", bus.avm_write, bus.avm_writedata, db); end
        wait_drain(10);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.cmd_valid       = ($urandom() % 2) == 0;
            bus.cmd_addr        = 9'($urandom_range(0, 12));
            bus.cmd_data        = $urandom();
            bus.avm_waitrequest = ($urandom() % 4) == 0;
            if (($urandom() % 16) == 0) vblank = ~vblank;
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.avm_waitrequest = 1'b0;
        vblank = 1'b1;
        wait_drain(100);
    endtask

    task automatic test_reset_burst();
        vblank = 1'b1;
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) drive_cmd(9'(i), $urandom());
        bus.avm_waitrequest = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks += 8;
        if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL rb_write: got %0b expected 0", bus.avm_write); end
        if (bus.avm_chipselect !== 1'b0) begin errors++; $display("FAIL rb_cs: got %0b expected 0", bus.avm_chipselect); end
        if (bus.avm_address !== 9'd0) begin errors++; $display("FAIL rb_addr: got %0d expected 0", bus.avm_address); end
        if (bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL rb_data: got %h expected 0", bus.avm_writedata); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL rb_level: got %0d expected 0", fifo_level); end
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rb_ready: got %0b expected 1", bus.cmd_ready); end
        if (write_count !== 16'd0) begin errors++; $display("FAIL rb_count: got %0d expected 0", write_count); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL rb_tick: got %0b expected 0", frame_tick); end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.avm_write !== 1'b0 || write_count !== 16'd0) begin
                errors++; $display("FAIL rb_after: got %0b/%0d expected 0/0", bus.avm_write, write_count);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_waitrequest();
        test_full();
`ifdef VGA_REG_WRITER_VBLANK_SYNC_EN
        test_gate();
        test_stall_vblank();
`endif
        test_random();
        test_reset_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
